// File: rtl/instr_encoder.sv
// instr_encoder: single-entry encoder for RV32 ADDI/LW/SW/BRANCH instruction words.
// Each encoded word is paired with a word-aligned instruction-memory address.
// Requests whose immediate is out of range are accepted and dropped,
// and counted in a saturating error counter.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  input  logic        addr_load,
  input  logic [31:0] addr_base,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    K_ADDI   = 2'd0,
    K_LW     = 2'd1,
    K_SW     = 2'd2,
    K_BRANCH = 2'd3
  } kind_e;

  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] addr_cnt;
  logic [31:0] enc;
  logic        imm_ok;
  logic        accept;
  logic        consume;
  logic        ok_is;
  logic        ok_b;

  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;
  assign consume   = out_valid && out_ready;
  assign out_addr  = addr_cnt;

  // Sign-extension checks: the bits above the encodable field must all match.
  assign ok_is = (&imm[31:11]) || !(|imm[31:11]);
  assign ok_b  = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];

  // Encode the request format and pick the range rule that matches its kind.
  always_comb begin
    enc    = 32'd0;
    imm_ok = 1'b0;
    case (kind_e'(req_kind))
      K_ADDI: begin
        enc    = {imm[11:0], rs1, funct3, rd, OP_ADDI};
        imm_ok = ok_is;
      end
      K_LW: begin
        enc    = {imm[11:0], rs1, funct3, rd, OP_LW};
        imm_ok = ok_is;
      end
      K_SW: begin
        enc    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_SW};
        imm_ok = ok_is;
      end
      K_BRANCH: begin
        enc    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        imm_ok = ok_b;
      end
      default: begin
        enc    = 32'd0;
        imm_ok = 1'b0;
      end
    endcase
  end

  // Output register: load on a good accept, drop on consume, hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
    end else if (accept && imm_ok) begin
      out_valid <= 1'b1;
      out_instr <= enc;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // Address counter: an explicit load takes priority over the post-handshake advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      addr_cnt <= 32'd0;
    else if (addr_load)
      addr_cnt <= addr_base & 32'hFFFF_FFFC;
    else if (consume)
      addr_cnt <= addr_cnt + 32'd4;
  end

  // Rejected-request counter, saturating at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_cnt <= 8'd0;
    else if (accept && !imm_ok && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus short random stimulus for instr_encoder.
// A negedge monitor keeps a scoreboard of expected words, an address model,
// and an error-count model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        addr_load;
  logic [31:0] addr_base;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_addr = 32'd0;
  int          m_err = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_instr, prev_addr;

  instr_encoder dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .addr_load(addr_load), .addr_base(addr_base), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from bit weights rather than concatenation.
  function automatic logic [31:0] model_enc(input logic [1:0] k, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
    logic [31:0] w;
    w = (32'(s1) << 15) | (32'(f3) << 12);
    case (k)
      2'd0: w = w | ((im & 32'hFFF) << 20) | (32'(d) << 7) | 32'h13;
      2'd1: w = w | ((im & 32'hFFF) << 20) | (32'(d) << 7) | 32'h03;
      2'd2: w = w | (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | ((im & 32'h1F) << 7) | 32'h23;
      default: w = w | (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                     | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
    endcase
    return w;
  endfunction

  function automatic bit model_ok(input logic [1:0] k, input logic [31:0] im);
    int signed v;
    v = signed'(im);
    if (k == 2'd3) return (v >= -4096) && (v <= 4094) && (im[0] == 1'b0);
    return (v >= -2048) && (v <= 2047);
  endfunction

  // Scoreboard monitor: the sampled values decide what happens at the next posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_addr = 32'd0;
      m_err = 0;
      stall_prev = 1'b0;
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!out_valid || out_ready));
      chk("out_addr", out_addr, m_addr);
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (stall_prev) begin
        chk("stall_instr", out_instr, prev_instr);
        chk("stall_addr", out_addr, prev_addr);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else chk("sb_instr", out_instr, exp_q[0]);
      end else begin
        chk("sb_pending", 32'(exp_q.size()), 32'd0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (req_valid && req_ready) begin
        if (model_ok(req_kind, imm)) exp_q.push_back(model_enc(req_kind, rd, rs1, rs2, funct3, imm));
        else if (m_err < 255) m_err++;
      end
      if (addr_load) m_addr = {addr_base[31:2], 2'b00};
      else if (out_valid && out_ready) m_addr = m_addr + 32'd4;
      stall_prev = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_addr  = out_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] k, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
    req_valid = v; req_kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
  endtask

  logic [31:0] held_i, held_a;

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b1;
    addr_load = 1'b0;
    addr_base = 32'd0;
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // ADDI x1, x0, 5
    set_req(1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, 32'd0);

    // LW with a concurrent load of 0: the load beats the ADDI handshake advance.
    set_req(1'b1, 2'd1, 5'd3, 5'd0, 5'd0, 3'd2, 32'hFFFF_FFFF);
    addr_load = 1'b1; addr_base = 32'd0;
    tick();
    addr_load = 1'b0;
    chk("lw_instr", out_instr, 32'hFFF02183);
    chk("lw_addr", out_addr, 32'd0);

    set_req(1'b1, 2'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    tick();
    chk("sw_instr", out_instr, 32'h0020A423);
    chk("sw_addr", out_addr, 32'd4);

    set_req(1'b1, 2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
    tick();
    chk("br_instr", out_instr, 32'hFE208EE3);
    chk("br_addr", out_addr, 32'd8);

    // Odd branch offset is rejected.
    set_req(1'b1, 2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    tick();
    chk("br_odd_valid", 32'(out_valid), 32'd0);
    chk("br_odd_err", 32'(err_cnt), 32'd1);

    // ADDI imm=2048 is out of range; counter must not move.
    set_req(1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    tick();
    chk("oor_valid", 32'(out_valid), 32'd0);
    chk("oor_err", 32'(err_cnt), 32'd2);
    chk("oor_addr", out_addr, 32'd12);
    for (int i = 0; i < 256; i++) tick();
    chk("err_sat", 32'(err_cnt), 32'd255);
    chk("err_sat_addr", out_addr, 32'd12);

    // Backpressure: three stalled cycles with a pending request.
    out_ready = 1'b0;
    set_req(1'b1, 2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1);
    tick();
    held_i = out_instr; held_a = out_addr;
    chk("bp_first", held_i, 32'h00100113);
    set_req(1'b1, 2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_instr", out_instr, held_i);
      chk("bp_addr", out_addr, held_a);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_instr", out_instr, 32'h00200113);
    chk("bp_next_addr", out_addr, 32'd16);
    set_req(1'b1, 2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'd3);
    tick();
    chk("bp_b2b_addr", out_addr, 32'd20);
    req_valid = 1'b0;
    tick();

    // Load during a handshake: the next word lands at the aligned base.
    set_req(1'b1, 2'd0, 5'd4, 5'd0, 5'd0, 3'd0, 32'd7);
    tick();
    chk("ld_pre_addr", out_addr, 32'd24);
    set_req(1'b1, 2'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'd9);
    addr_load = 1'b1; addr_base = 32'h0000_1003;
    tick();
    addr_load = 1'b0;
    chk("ld_addr", out_addr, 32'h0000_1000);

    // Reset with a held word.
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_addr", out_addr, 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    chk("rst2_ready", 32'(req_ready), 32'd1);

    // Random mix checked by the monitor.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] k;
      logic [31:0] im;
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) im = 32'($urandom_range(0, 8191)) - 32'd4096;
      else if (k == 2'd3) im = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      else im = 32'($urandom_range(0, 4095)) - 32'd2048;
      set_req(1'($urandom_range(0, 1)), k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), im);
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port req_valid, input, 1 bit: an encode request is present.
REQ-004 The block SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-005 The block SHALL have port req_kind, input, 2 bits: 0=ADDI, 1=LW, 2=SW, 3=BRANCH.
REQ-006 The block SHALL have ports rd, rs1 and rs2, inputs, 5 bits each: register fields.
REQ-007 The block SHALL have port funct3, input, 3 bits: passed to instr[14:12].
REQ-008 The block SHALL have port imm, input, 32 bits: signed two's-complement immediate or offset.
REQ-009 The block SHALL have port out_valid, output, 1 bit: an encoded word is held.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the word.
REQ-011 The block SHALL have port out_instr, output, 32 bits: the encoded instruction.
REQ-012 The block SHALL have port out_addr, output, 32 bits: the word-aligned instruction-memory address for out_instr.
REQ-013 The block SHALL have port addr_load, input, 1 bit, and port addr_base, input, 32 bits: load the address counter.
REQ-014 The block SHALL have port err_cnt, output, 8 bits: saturating count of rejected requests.

Function
REQ-015 A request SHALL be accepted when req_valid and req_ready are both 1; an output SHALL be consumed when out_valid and out_ready are both 1.
REQ-016 req_ready SHALL equal (!out_valid || out_ready), giving a single-entry pipeline with full throughput of 1 word/cycle.
REQ-017 Latency SHALL be 1 cycle: the encoding of a request accepted at edge N SHALL appear on out_instr with out_valid=1 after edge N.
REQ-018 For kind 0 the opcode SHALL be 0010011 and kind 1 SHALL be 0000011, both I-type: instr = {imm[11:0], rs1, funct3, rd, opcode}; rs2 is ignored.
REQ-019 For kind 2 the opcode SHALL be 0100011, S-type: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd is ignored.
REQ-020 For kind 3 the opcode SHALL be 1100011, B-type: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; rd is ignored.
REQ-021 I/S range check: imm SHALL lie in -2048..2047, i.e. imm[31:11] all equal.
REQ-022 B range check: imm SHALL lie in -4096..4094, i.e. imm[31:12] all equal, and imm[0] SHALL be 0.
REQ-023 An out-of-range request SHALL still be accepted (handshake completes), SHALL NOT produce an output, and SHALL increment err_cnt, saturating at 255.
REQ-024 While out_valid=1 and out_ready=0, out_instr and out_addr SHALL hold stable and no request SHALL be accepted.
REQ-025 The address counter SHALL advance by 4 on every output handshake; out_addr SHALL show the counter value associated with the held word.
REQ-026 addr_load SHALL set the counter to {addr_base[31:2], 2'b00} at the next edge; if it coincides with an output handshake, the load SHALL win; wrap-around at 0xFFFFFFFC+4 SHALL go to 0.
REQ-027 A simultaneous output handshake and new valid request SHALL replace the held word in the same edge, with no bubble.

Reset
REQ-028 When reset_n=0, asynchronously: out_valid SHALL be 0, out_instr SHALL be 0, the address counter and out_addr SHALL be 0, and err_cnt SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; req_ready SHALL be 1 in the first cycle after reset_n rises.

Verification
REQ-030 Bench: ADDI rd=1 rs1=0 funct3=0 imm=5 -> out_instr=0x00500093 and out_addr=0 one cycle later.
REQ-031 Bench: LW rd=3 rs1=0 funct3=2 imm=-1 -> 0xFFF02183; then SW rs1=1 rs2=2 funct3=2 imm=8 -> 0x0020A423 at out_addr=4.
REQ-032 Bench: BRANCH rs1=1 rs2=2 funct3=0 imm=-4 -> 0xFE208EE3; BRANCH imm=3 (odd) -> no output and err_cnt=1.
REQ-033 Bench: ADDI imm=2048 -> accepted, no out_valid, err_cnt increments, address counter unchanged; 256 such requests -> err_cnt=255.
REQ-034 Bench: hold out_ready=0 for 3 cycles with req_valid=1 -> out_instr and out_addr stable, req_ready=0; release -> back-to-back outputs with addresses incrementing by 4.
REQ-035 Bench: addr_load=1 with addr_base=0x00001003 during a handshake -> next out_addr=0x00001000; reset_n pulsed low with out_valid=1 -> all outputs 0 immediately.
